// File: rtl/c7b_axi_pkg.sv
// Shared types and constants for the c7b AXI read-channel arbiter.
// The state encoding, AXI constants and default IDs live here so the top and picker agree.
package c7b_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } rd_state_e;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] ARSIZE_BYTE    = 3'b000;
  localparam logic [2:0] ARSIZE_HALF    = 3'b001;
  localparam logic [2:0] ARSIZE_WORD    = 3'b010;
  localparam logic [3:0] DEF_IFU_ID     = 4'h0;
  localparam logic [3:0] DEF_LSU_ID     = 4'h1;

  // A returned beat is bad if the slave flagged it, it carries the wrong tag, or it is not the last beat.
  function automatic logic beat_err(input logic [1:0] resp, input logic [3:0] id,
                                    input logic [3:0] tag, input logic last);
    return (resp != AXI_RESP_OKAY) || (id != tag) || !last;
  endfunction

endpackage

// File: rtl/c7b_rd_arb_pick.sv
// Combinational winner select between fetch and load requesters.
// LSU wins by default; IFU wins when alone or once it has lost STARVE_MAX contested rounds in a row.
module c7b_rd_arb_pick
  import c7b_axi_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic       ifu_valid,
  input  logic       lsu_valid,
  input  logic [3:0] starve_cnt,
  output logic       grant_ifu,
  output logic       grant_lsu,
  output logic       contested
);

  localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

  // Winner selection
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    contested = ifu_valid && lsu_valid;
    if (ifu_valid && (!lsu_valid || (starve_cnt == STARVE_MAX_C))) begin
      grant_ifu = 1'b1;
    end else if (lsu_valid) begin
      grant_lsu = 1'b1;
    end else begin
      grant_ifu = 1'b0;
      grant_lsu = 1'b0;
    end
  end

endmodule

// File: rtl/c7b_axi_rd_arb.sv
// Shares the c7b core's single AXI read channel between IFU and LSU.
// One single-beat transaction at a time: accept, issue AR, collect R, return to the owner.
module c7b_axi_rd_arb
  import c7b_axi_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter logic [3:0]  IFU_ID     = DEF_IFU_ID,
  parameter logic [3:0]  LSU_ID     = DEF_LSU_ID
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifu_req_valid,
  input  logic [31:0] ifu_req_addr,
  output logic        ifu_req_ready,
  output logic        ifu_ret_valid,
  output logic [31:0] ifu_ret_data,
  output logic        ifu_ret_err,
  input  logic        lsu_req_valid,
  input  logic [31:0] lsu_req_addr,
  input  logic [1:0]  lsu_req_size,
  output logic        lsu_req_ready,
  output logic        lsu_ret_valid,
  output logic [31:0] lsu_ret_data,
  output logic        lsu_ret_err,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [3:0]  arid,
  output logic [2:0]  arsize,
  output logic [7:0]  arlen,
  output logic [1:0]  arburst,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [3:0]  rid,
  input  logic [1:0]  rresp,
  input  logic        rlast
);

  localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

  rd_state_e  state_r;
  rd_state_e  state_nxt_s;
  logic [3:0] starve_cnt_r;
  logic       owner_ifu_r;
  logic       grant_ifu_s;
  logic       grant_lsu_s;
  logic       contested_s;
  logic       accept_s;
  logic       ar_hs_s;
  logic       r_hs_s;
  logic [3:0] owner_tag_s;

  c7b_rd_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
    .starve_cnt (starve_cnt_r),
    .grant_ifu  (grant_ifu_s),
    .grant_lsu  (grant_lsu_s),
    .contested  (contested_s)
  );

  assign accept_s    = ifu_req_ready || lsu_req_ready;
  assign ar_hs_s     = arvalid && arready;
  assign r_hs_s      = rvalid && rready;
  assign owner_tag_s = owner_ifu_r ? IFU_ID : LSU_ID;
  assign arlen       = 8'h00;
  assign arburst     = AXI_BURST_INCR;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: if (accept_s) state_nxt_s = ST_AR;   else state_nxt_s = ST_IDLE;
      ST_AR:   if (ar_hs_s)  state_nxt_s = ST_R;    else state_nxt_s = ST_AR;
      ST_R:    if (r_hs_s)   state_nxt_s = ST_IDLE; else state_nxt_s = ST_R;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode; ready is gated by reset so nothing is accepted while reset is held
  always_comb begin
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    arvalid       = 1'b0;
    rready        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        ifu_req_ready = grant_ifu_s && !reset;
        lsu_req_ready = grant_lsu_s && !reset;
      end
      ST_AR:   arvalid = 1'b1;
      ST_R:    rready  = 1'b1;
      default: begin
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        arvalid       = 1'b0;
        rready        = 1'b0;
      end
    endcase
  end

  // Latch AR fields and owner at acceptance; held stable through the AR stall
  always_ff @(posedge clk) begin
    if (reset) begin
      araddr      <= 32'h0000_0000;
      arid        <= 4'h0;
      arsize      <= 3'b000;
      owner_ifu_r <= 1'b0;
    end else if (ifu_req_ready) begin
      araddr      <= ifu_req_addr;
      arid        <= IFU_ID;
      arsize      <= ARSIZE_WORD;
      owner_ifu_r <= 1'b1;
    end else if (lsu_req_ready) begin
      araddr      <= lsu_req_addr;
      arid        <= LSU_ID;
      arsize      <= {1'b0, lsu_req_size};
      owner_ifu_r <= 1'b0;
    end
  end

  // Starvation counter: counts LSU wins while IFU was also waiting
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_r <= 4'd0;
    end else if (ifu_req_ready) begin
      starve_cnt_r <= 4'd0;
    end else if (lsu_req_ready) begin
      if (!contested_s)                      starve_cnt_r <= 4'd0;
      else if (starve_cnt_r != STARVE_MAX_C) starve_cnt_r <= starve_cnt_r + 4'd1;
    end
  end

  // Capture the R beat and pulse the owner's return one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      ifu_ret_valid <= 1'b0;
      lsu_ret_valid <= 1'b0;
      ifu_ret_data  <= 32'h0000_0000;
      lsu_ret_data  <= 32'h0000_0000;
      ifu_ret_err   <= 1'b0;
      lsu_ret_err   <= 1'b0;
    end else begin
      ifu_ret_valid <= r_hs_s && owner_ifu_r;
      lsu_ret_valid <= r_hs_s && !owner_ifu_r;
      if (r_hs_s && owner_ifu_r) begin
        ifu_ret_data <= rdata;
        ifu_ret_err  <= beat_err(rresp, rid, owner_tag_s, rlast);
      end
      if (r_hs_s && !owner_ifu_r) begin
        lsu_ret_data <= rdata;
        lsu_ret_err  <= beat_err(rresp, rid, owner_tag_s, rlast);
      end
    end
  end

endmodule

// File: tb/tb_c7b_axi_rd_arb.sv
// Randomised and directed bench for c7b_axi_rd_arb with a transaction-level reference model.
module tb_c7b_axi_rd_arb;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ifu_req_valid = 1'b0;
  logic [31:0] ifu_req_addr = 32'h0;
  logic        ifu_req_ready, ifu_ret_valid, ifu_ret_err;
  logic [31:0] ifu_ret_data;
  logic        lsu_req_valid = 1'b0;
  logic [31:0] lsu_req_addr = 32'h0;
  logic [1:0]  lsu_req_size = 2'd0;
  logic        lsu_req_ready, lsu_ret_valid, lsu_ret_err;
  logic [31:0] lsu_ret_data;
  logic        arvalid, rready;
  logic        arready = 1'b0;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [2:0]  arsize;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic [3:0]  rid = 4'h0;
  logic [1:0]  rresp = 2'b00;
  logic        rlast = 1'b1;

  c7b_axi_rd_arb #(.STARVE_MAX(STARVE_MAX), .IFU_ID(4'h0), .LSU_ID(4'h1)) dut (
    .clk(clk), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr), .ifu_req_ready(ifu_req_ready),
    .ifu_ret_valid(ifu_ret_valid), .ifu_ret_data(ifu_ret_data), .ifu_ret_err(ifu_ret_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_addr(lsu_req_addr), .lsu_req_size(lsu_req_size),
    .lsu_req_ready(lsu_req_ready), .lsu_ret_valid(lsu_ret_valid), .lsu_ret_data(lsu_ret_data),
    .lsu_ret_err(lsu_ret_err),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arsize(arsize),
    .arlen(arlen), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: one outstanding transaction record plus a pending return.
  bit          m_ok = 1'b0, m_busy, m_ar_done, m_owner_ifu, m_ret_pend, m_ret_ifu, m_ret_err;
  logic [31:0] m_addr, m_ret_data;
  logic [3:0]  m_id;
  logic [2:0]  m_size;
  int          m_starve;
  bit          e_ir, e_lr;

  always @(negedge clk) begin
    e_ir = !reset && m_ok && !m_busy && ifu_req_valid && (!lsu_req_valid || m_starve == STARVE_MAX);
    e_lr = !reset && m_ok && !m_busy && lsu_req_valid && !e_ir;
    if (m_ok) begin
      check("cyc_ctrl",
            {ifu_req_ready, lsu_req_ready, arvalid, rready, ifu_ret_valid, lsu_ret_valid, arlen, arburst},
            {e_ir, e_lr, m_busy && !m_ar_done, m_busy && m_ar_done,
             m_ret_pend && m_ret_ifu, m_ret_pend && !m_ret_ifu, 8'h00, 2'b01});
      if (m_busy && !m_ar_done) check("cyc_ar", {araddr, arid, arsize}, {m_addr, m_id, m_size});
      if (m_ret_pend && m_ret_ifu)  check("cyc_ret_ifu", {ifu_ret_data, ifu_ret_err}, {m_ret_data, m_ret_err});
      if (m_ret_pend && !m_ret_ifu) check("cyc_ret_lsu", {lsu_ret_data, lsu_ret_err}, {m_ret_data, m_ret_err});
    end
    if (reset) begin
      m_ok = 1'b1; m_busy = 1'b0; m_ar_done = 1'b0; m_ret_pend = 1'b0; m_starve = 0;
    end else if (m_ok) begin
      m_ret_pend = 1'b0;
      if (e_ir) begin
        m_busy = 1'b1; m_owner_ifu = 1'b1; m_addr = ifu_req_addr; m_size = 3'd2; m_id = 4'h0;
        m_starve = 0;
      end else if (e_lr) begin
        m_busy = 1'b1; m_owner_ifu = 1'b0; m_addr = lsu_req_addr; m_size = {1'b0, lsu_req_size};
        m_id = 4'h1;
        m_starve = ifu_req_valid ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
      end else if (m_busy && !m_ar_done) begin
        if (arready) m_ar_done = 1'b1;
      end else if (m_busy && rvalid) begin
        m_ret_pend = 1'b1; m_ret_ifu = m_owner_ifu; m_ret_data = rdata;
        m_ret_err  = (rresp != 2'b00) || (rid != m_id) || !rlast;
        m_busy = 1'b0; m_ar_done = 1'b0;
      end
    end
  end

  // Stimulus-side observation and slave state
  bit          taken_i, taken_l, ar_hs, r_hs, s_rready;
  int          cyc;
  int          rec_rdy_i, rec_rdy_l, rec_ret_i, rec_ret_l, rec_ret_cyc;
  logic [31:0] rec_data;
  logic        rec_err;
  logic [31:0] rec_araddr;
  logic [3:0]  rec_arid;
  logic [2:0]  rec_arsize;
  bit          rec_ar_cap, rec_ar_unstable, ar_active;
  logic [38:0] prev_ar;
  bit          grant_log[$];
  bit          sl_pending, sl_hold = 1'b0, ar_rand = 1'b0, fix_en = 1'b0;
  bit          ifu_keep = 1'b0, lsu_keep = 1'b0;
  logic [3:0]  sl_id;
  logic [31:0] fix_data;
  int          sl_delay, arv_cnt = 0, ar_stall = 0, r_delay_max = 0, err_mode = 0;

  task automatic rec_clear();
    cyc = 0; rec_rdy_i = 0; rec_rdy_l = 0; rec_ret_i = 0; rec_ret_l = 0; rec_ret_cyc = -1;
    rec_data = 32'h0; rec_err = 1'b0; rec_ar_cap = 1'b0; rec_ar_unstable = 1'b0;
    grant_log.delete();
  endtask

  task automatic sample();
    @(negedge clk);
    taken_i = ifu_req_ready; taken_l = lsu_req_ready;
    ar_hs = arvalid && arready; r_hs = rvalid && rready; s_rready = rready;
    if (taken_i) begin rec_rdy_i++; grant_log.push_back(1'b1); end
    if (taken_l) begin rec_rdy_l++; grant_log.push_back(1'b0); end
    if (arvalid) begin
      if (!rec_ar_cap) begin
        rec_araddr = araddr; rec_arid = arid; rec_arsize = arsize; rec_ar_cap = 1'b1;
      end
      if (ar_active && (prev_ar != {araddr, arid, arsize})) rec_ar_unstable = 1'b1;
      prev_ar = {araddr, arid, arsize};
      ar_active = !ar_hs;
      arv_cnt++;
    end
    if (ifu_ret_valid) begin rec_ret_i++; rec_ret_cyc = cyc; rec_data = ifu_ret_data; rec_err = ifu_ret_err; end
    if (lsu_ret_valid) begin rec_ret_l++; rec_ret_cyc = cyc; rec_data = lsu_ret_data; rec_err = lsu_ret_err; end
    if (ar_hs) begin
      sl_pending = 1'b1; sl_id = arid; arv_cnt = 0;
      sl_delay = (r_delay_max == 0) ? 0 : int'($urandom_range(0, r_delay_max));
    end
    cyc++;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (reset) begin
      sl_pending = 1'b0; rvalid = 1'b0; arv_cnt = 0; ar_active = 1'b0;
    end else begin
      if (r_hs) rvalid = 1'b0;
      arready = ar_rand ? 1'($urandom_range(0, 1)) : (arv_cnt >= ar_stall);
      if (sl_pending && !rvalid && !sl_hold) begin
        if (sl_delay > 0) sl_delay--;
        else begin
          rvalid = 1'b1; rdata = fix_en ? fix_data : $urandom; rid = sl_id; rresp = 2'b00; rlast = 1'b1;
          sl_pending = 1'b0;
          case (err_mode)
            1: rresp = 2'b10;
            2: rid = 4'h5;
            3: rlast = 1'b0;
            4: case ($urandom_range(0, 7))
                 0: rresp = 2'($urandom_range(1, 3));
                 1: rid = sl_id ^ 4'h5;
                 2: rlast = 1'b0;
                 default: ;
               endcase
            default: ;
          endcase
        end
      end
    end
  endtask

  task automatic run(input int n_rets, input int max_grants, input int bound);
    for (int k = 0; k < bound && (rec_ret_i + rec_ret_l) < n_rets; k++) begin
      sample();
      advance();
      if (taken_i) begin
        if (ifu_keep) ifu_req_addr = ifu_req_addr + 32'd4; else ifu_req_valid = 1'b0;
      end
      if (taken_l) begin
        if (lsu_keep) lsu_req_addr = lsu_req_addr + 32'd4; else lsu_req_valid = 1'b0;
      end
      if (grant_log.size() >= max_grants) begin ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin sample(); advance(); end
  endtask

  task automatic check_quiet(input string nm);
    check(nm, {ifu_req_ready, lsu_req_ready, arvalid, rready, ifu_ret_valid, lsu_ret_valid,
               ifu_ret_err, lsu_ret_err, araddr, arid, arsize, ifu_ret_data, lsu_ret_data}, 128'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Both requesters valid while reset is held
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h1c00_0000;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h2000_0000; lsu_req_size = 2'd2;
    idle(3);
    sample();
    check_quiet("reset_state");
    advance();
    reset = 1'b0;
    rec_clear();
    run(2, 2, 30);
    check("release_grants", grant_log.size(), 2);
    check("release_first_lsu", {grant_log[0], grant_log[1]}, 2'b01);
    idle(2);

    // LSU only, immediate slave
    rec_clear(); fix_en = 1'b1; fix_data = 32'h0000_0007;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h1c00_0100; lsu_req_size = 2'd2;
    run(1, 1, 20);
    check("t1_ready_once", rec_rdy_l, 1);
    check("t1_ar", {rec_araddr, rec_arid, rec_arsize}, {32'h1c00_0100, 4'h1, 3'd2});
    check("t1_ret_cycle", rec_ret_cyc, 3);
    check("t1_ret", {rec_ret_l, rec_ret_i, rec_data, rec_err}, {32'd1, 32'd0, 32'h7, 1'b0});
    idle(2);

    // IFU only with arready held low for 3 cycles
    rec_clear(); ar_stall = 3; fix_data = 32'h0000_0013;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h1c00_0028;
    run(1, 1, 20);
    check("t2_ar_stable", rec_ar_unstable, 1'b0);
    check("t2_ar", {rec_araddr, rec_arid, rec_arsize}, {32'h1c00_0028, 4'h0, 3'd2});
    check("t2_once", {rec_rdy_i, rec_ret_i, rec_ret_l}, {32'd1, 32'd1, 32'd0});
    check("t2_ret_cycle", rec_ret_cyc, 6);
    ar_stall = 0;
    idle(2);

    // Continuous contention
    rec_clear(); ifu_keep = 1'b1; lsu_keep = 1'b1; fix_en = 1'b0;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h1c00_1000;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h2000_1000; lsu_req_size = 2'd2;
    run(10, 10, 80);
    check("t3_grants", grant_log.size(), 10);
    for (int i = 0; i < 10; i++) check($sformatf("t3_grant%0d", i), grant_log[i], (i % 5) == 4);
    check("t3_rets", {rec_ret_i, rec_ret_l}, {32'd2, 32'd8});
    ifu_keep = 1'b0; lsu_keep = 1'b0;
    idle(2);

    // SLVERR on a load, then a clean load
    rec_clear(); fix_en = 1'b1; fix_data = 32'hdead_beef; err_mode = 1;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h2000_0040; lsu_req_size = 2'd1;
    run(1, 1, 20);
    check("t4_err", {rec_ret_l, rec_data, rec_err}, {32'd1, 32'hdead_beef, 1'b1});
    rec_clear(); err_mode = 0; fix_data = 32'h1234_5678;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h2000_0044; lsu_req_size = 2'd0;
    run(1, 1, 20);
    check("t4_clean", {rec_ret_l, rec_data, rec_err}, {32'd1, 32'h1234_5678, 1'b0});

    // Bad RID, then missing RLAST, on fetches
    rec_clear(); err_mode = 2;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h1c00_0080;
    run(1, 1, 20);
    check("t5_rid", {rec_ret_i, rec_err}, {32'd1, 1'b1});
    rec_clear(); err_mode = 3;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h1c00_0084;
    run(1, 1, 20);
    check("t5_rlast", {rec_ret_i, rec_err}, {32'd1, 1'b1});
    err_mode = 0;

    // Reset while waiting in R
    rec_clear(); sl_hold = 1'b1;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h1c00_00c0;
    s_rready = 1'b0;
    for (int k = 0; k < 20 && !s_rready; k++) begin
      sample(); advance();
      if (taken_i) ifu_req_valid = 1'b0;
    end
    check("t6_in_r", s_rready, 1'b1);
    reset = 1'b1;
    sample(); advance();
    reset = 1'b0; sl_hold = 1'b0;
    sample();
    check_quiet("t6_after_reset");
    advance();
    rec_clear(); fix_data = 32'h0000_0aa5;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h1c00_00c4;
    run(1, 1, 20);
    check("t6_refetch", {rec_ret_i, rec_ret_l, rec_data, rec_err}, {32'd1, 32'd0, 32'h0aa5, 1'b0});

    // Randomised traffic checked cycle by cycle against the model
    rec_clear(); ar_rand = 1'b1; r_delay_max = 2; err_mode = 4; fix_en = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      sample(); advance();
      if (taken_i) ifu_req_valid = 1'b0;
      if (!ifu_req_valid) begin
        if ($urandom_range(0, 2) == 0) begin ifu_req_valid = 1'b1; ifu_req_addr = $urandom & 32'hffff_fffc; end
      end else if ($urandom_range(0, 15) == 0) ifu_req_valid = 1'b0;
      if (taken_l) lsu_req_valid = 1'b0;
      if (!lsu_req_valid) begin
        if ($urandom_range(0, 1) == 0) begin
          lsu_req_valid = 1'b1; lsu_req_addr = $urandom; lsu_req_size = 2'($urandom_range(0, 2));
        end
      end else if ($urandom_range(0, 15) == 0) lsu_req_valid = 1'b0;
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    idle(40);
    check("rand_balance", rec_rdy_i + rec_rdy_l, rec_ret_i + rec_ret_l);
    check("rand_ifu_seen", rec_ret_i > 0, 1'b1);
    check("rand_lsu_seen", rec_ret_l > 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
